// File: rtl/tp_probe_pkg.sv
// Shared types and constants for the test-point probe router.
package tp_probe_pkg;

  localparam int TRIG_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2,
    HOLD  = 2'd3
  } trig_state_t;

endpackage

// File: rtl/tp_pulse_stretch.sv
// Per-bit pulse stretcher: a rising edge on a masked bit keeps the output
// high for STRETCH cycles; unmasked bits pass straight through. Output is registered.
module tp_pulse_stretch import tp_probe_pkg::*; #(
  parameter int WIDTH   = 16,
  parameter int STRETCH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic [WIDTH-1:0] MASK,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q
);

  localparam int CNT_W = (STRETCH < 2) ? 1 : $clog2(STRETCH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STRETCH - 1);

  logic [WIDTH-1:0] d_prev;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] stretched;

  // Combine the live bit with its remaining stretch time.
  always_comb begin
    stretched = '0;
    for (int i = 0; i < WIDTH; i++) begin
      stretched[i] = D[i] | (MASK[i] & (cnt[i] != '0));
    end
  end

  // Edge detect, per-bit countdown and output register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      d_prev <= '0;
      Q      <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      d_prev <= D;
      Q      <= stretched;
      for (int i = 0; i < WIDTH; i++) begin
        // A clear or an unmasked bit drops any stretch in progress.
        if (CLR || !MASK[i]) begin
          cnt[i] <= '0;
        end else if (D[i] && !d_prev[i]) begin
          cnt[i] <= CNT_LOAD;
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tp_probe_router.sv
// Test-point router: selects one of NGRP probe groups onto WIDTH pins with
// blanking on selection change, per-bit pulse stretching and an armable
// pattern trigger producing a scope-sync pulse.
module tp_probe_router import tp_probe_pkg::*; #(
  parameter int NGRP     = 4,
  parameter int WIDTH    = 16,
  parameter int SEL_INIT = 0,
  parameter int STRETCH  = 8,
  parameter int BLANK    = 4,
  parameter int HOLDOFF  = 64,
  parameter logic [WIDTH-1:0] DIR_MASK = '0
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [NGRP*WIDTH-1:0]   PROBES,
  input  logic                    SEL_WE,
  input  logic [$clog2(NGRP)-1:0] SEL_DATA,
  input  logic [WIDTH-1:0]        STRETCH_MASK,
  input  logic [WIDTH-1:0]        TRIG_MASK,
  input  logic                    TRIG_ARM,
  input  logic                    TRIG_DISARM,
  input  logic                    TRIG_CONT,
  output logic [WIDTH-1:0]        TP_OUT,
  output logic [WIDTH-1:0]        TP_DIR,
  output logic [$clog2(NGRP)-1:0] CUR_SEL,
  output logic                    SEL_ERR,
  output logic                    TRIG_OUT,
  output logic                    TRIG_ARMED,
  output logic [TRIG_CNT_W-1:0]   TRIG_CNT
);

  localparam int SEL_W   = $clog2(NGRP);
  localparam int BLANK_W = (BLANK < 1) ? 1 : $clog2(BLANK + 1);
  localparam int HOLD_W  = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF);

  function automatic logic [TRIG_CNT_W-1:0] sat_inc(input logic [TRIG_CNT_W-1:0] v);
    if (v == '1) return v;
    return v + 1'b1;
  endfunction

  logic [NGRP*WIDTH-1:0] probes_p0;
  logic [WIDTH-1:0]      sel_p1;
  logic [WIDTH-1:0]      grp_mux;
  logic [SEL_W-1:0]      cur_sel_q;
  logic [BLANK_W-1:0]    blank_cnt_q;
  logic                  sel_err_q;
  logic                  sel_in_range;
  logic                  sel_chg;
  logic                  blanking;
  logic                  match;
  trig_state_t           state_q, state_d;
  logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
  logic [TRIG_CNT_W-1:0] trig_cnt_q;

  assign sel_in_range = 32'(SEL_DATA) < NGRP;
  assign sel_chg      = SEL_WE && sel_in_range && (SEL_DATA != cur_sel_q);
  assign blanking     = blank_cnt_q != '0;

  // Selection register, blanking countdown and invalid-write flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cur_sel_q   <= SEL_W'(SEL_INIT);
      blank_cnt_q <= '0;
      sel_err_q   <= 1'b0;
    end else begin
      sel_err_q <= SEL_WE && !sel_in_range;
      if (sel_chg) begin
        cur_sel_q   <= SEL_DATA;
        blank_cnt_q <= BLANK_W'(BLANK);
      end else if (blanking) begin
        blank_cnt_q <= blank_cnt_q - 1'b1;
      end
    end
  end

  // Pick the active group out of the registered probe bus.
  always_comb begin
    grp_mux = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (cur_sel_q == SEL_W'(g)) grp_mux = probes_p0[g*WIDTH +: WIDTH];
    end
  end

  // Probe capture and selected-group register; reset so the pipe starts clean.
  always_ff @(posedge CLK) begin
    if (RST) begin
      probes_p0 <= '0;
      sel_p1    <= '0;
    end else begin
      // stage p0: raw probes
      probes_p0 <= PROBES;
      // stage p1: selected group, forced low while blanking
      sel_p1    <= blanking ? '0 : grp_mux;
    end
  end

  // stage p2: stretcher output register drives the pins
  tp_pulse_stretch #(
    .WIDTH   (WIDTH),
    .STRETCH (STRETCH)
  ) u_stretch (
    .CLK  (CLK),
    .RST  (RST),
    .CLR  (blanking),
    .MASK (STRETCH_MASK),
    .D    (sel_p1),
    .Q    (TP_OUT)
  );

  assign match = (TRIG_MASK != '0) && ((sel_p1 & TRIG_MASK) == TRIG_MASK);

  // Trigger next-state logic; disarm overrides everything else.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE:  if (TRIG_ARM) state_d = ARMED;
      ARMED: if (match) state_d = FIRED;
      FIRED: begin
        state_d    = HOLD;
        hold_cnt_d = HOLD_W'(HOLDOFF - 1);
      end
      HOLD: begin
        if (hold_cnt_q == '0) state_d = TRIG_CONT ? ARMED : IDLE;
        else                  hold_cnt_d = hold_cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (TRIG_DISARM) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
    end
  end

  // Trigger state, holdoff counter and saturating fire count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      trig_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      if (state_q == FIRED) trig_cnt_q <= sat_inc(trig_cnt_q);
    end
  end

  assign TP_DIR     = DIR_MASK;
  assign CUR_SEL    = cur_sel_q;
  assign SEL_ERR    = sel_err_q;
  assign TRIG_OUT   = (state_q == FIRED);
  assign TRIG_ARMED = (state_q == ARMED);
  assign TRIG_CNT   = trig_cnt_q;

endmodule
